demux32_1_2_reg: RTL and testbench
==================================

DEMUX32_1_2_REG -- requirements
Module: demux32_1_2_reg

Interface
REQ-001 SHALL have parameter W, default 32: data width of X, Y0 and Y1.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port X, input, W: input data word.
REQ-005 SHALL have port S, input, 1: destination select, sampled with X; 0 selects Y0, 1 selects Y1.
REQ-006 SHALL have port X_valid, input, 1: X and S are valid this cycle.
REQ-007 SHALL have port X_ready, output, 1: the block accepts X this cycle.
REQ-008 SHALL have ports Y0 and Y1, output, W each: registered output data, one per destination.
REQ-009 SHALL have ports Y0_valid and Y1_valid, output, 1 each: the matching Yn holds an undelivered word.
REQ-010 SHALL have ports Y0_ready and Y1_ready, input, 1 each: the matching downstream consumes Yn this cycle.
REQ-011 SHALL have ports CNT0 and CNT1, output, 16 each: counts of words delivered on Y0 and Y1.

Function
REQ-012 SHALL transfer a word on any port when that port's valid and ready are both 1 in the same cycle.
REQ-013 SHALL hold one single-entry output register per port, each with its own full flag.
REQ-014 SHALL drive X_ready = (S==0) ? (!Y0_valid | Y0_ready) : (!Y1_valid | Y1_ready), combinationally.
REQ-015 SHALL load X into register S on an input transfer; the word appears on Y[S] with Y[S]_valid=1 one cycle later (latency 1).
REQ-016 SHALL leave the unselected register's data and valid unchanged on an input transfer.
REQ-017 SHALL clear Yn_valid when Yn is delivered and no new word loads into port n in the same cycle.
REQ-018 SHALL, when port n is delivered and reloaded in the same cycle, keep Yn_valid=1 and present the new word (full throughput, no bubble).
REQ-019 SHALL hold Yn and Yn_valid stable while Yn_valid=1 and Yn_ready=0, with no loss and no overwrite.
REQ-020 SHALL let a stall on one port block only input words selected to that port; the other port keeps draining.
REQ-021 SHALL deliver Y0 and Y1 independently in the same cycle when both are valid and ready.
REQ-022 SHALL ignore X and S when X_valid=0; no state changes.
REQ-023 SHALL, with DEMUX_CNT_EN defined, increment CNTn by 1 on each Yn transfer, wrapping from 16'hFFFF to 16'h0000.

Reset
REQ-024 SHALL, while rst=1 at a clock edge, set Y0, Y1 to 0, Y0_valid and Y1_valid to 0, and CNT0 and CNT1 to 0.
REQ-025 SHALL discard any word held or in transfer when reset is asserted mid-operation; no transfer completes in a reset cycle.
REQ-026 SHALL force X_ready to 0 while rst=1.

Configuration
REQ-027 SHALL compile the delivery counters in only when macro DEMUX_CNT_EN is defined.
REQ-028 SHALL, when DEMUX_CNT_EN is not defined, omit the counter registers and tie CNT0 and CNT1 to constant 0; all other behaviour is unchanged.

Verification
REQ-029 SHALL cover routing: reset, then X=32'hA5A5_0001, S=0, X_valid=1 for one cycle, Y0_ready=1 -> next cycle Y0=32'hA5A5_0001, Y0_valid=1; Y1_valid stays 0.
REQ-030 SHALL cover backpressure: Y1_ready=0, send 32'h1111 then 32'h2222 with S=1 -> Y1 holds 32'h1111 and X_ready=0 for the second word; raise Y1_ready -> 32'h2222 is accepted and appears next cycle.
REQ-031 SHALL cover independence: Y1 stalled and full, send 32'h3333 with S=0 -> X_ready=1 and Y0=32'h3333 next cycle.
REQ-032 SHALL cover throughput: 8 back-to-back words to S=0 with Y0_ready=1 -> 8 consecutive Y0_valid cycles, in order, no bubbles; with DEMUX_CNT_EN defined, CNT0=8.
REQ-033 SHALL cover counter wrap and reset: with DEMUX_CNT_EN defined, deliver 65537 words on Y1 -> CNT1=1; then assert rst with Y0_valid=1 -> next cycle all outputs 0.
REQ-034 SHALL cover the build without DEMUX_CNT_EN: run scenario REQ-032 -> CNT0 and CNT1 stay 0; data behaviour is identical.

Source files
------------

// File: rtl/demux32_1_2_reg.sv
// 1-to-2 registered demultiplexer with valid/ready handshakes on every port.
// Optional per-port delivery counters are built only when DEMUX_CNT_EN is defined.
module demux32_1_2_reg #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] X,
   input  logic         S,
   input  logic         X_valid,
   output logic         X_ready,
   output logic [W-1:0] Y0,
   output logic [W-1:0] Y1,
   output logic         Y0_valid,
   output logic         Y1_valid,
   input  logic         Y0_ready,
   input  logic         Y1_ready,
   output logic [15:0]  CNT0,
   output logic [15:0]  CNT1
);

   logic [W-1:0] y0_q, y0_d;
   logic [W-1:0] y1_q, y1_d;
   logic         y0_valid_q, y0_valid_d;
   logic         y1_valid_q, y1_valid_d;

   logic in_fire;
   logic load0, load1;
   logic deliver0, deliver1;

   // A port can take a new word when it is empty or is draining this cycle.
   always_comb begin
      X_ready = 1'b0;
      if (!rst) begin
         X_ready = S ? (!y1_valid_q || Y1_ready) : (!y0_valid_q || Y0_ready);
      end
   end

   always_comb begin
      in_fire  = X_valid && X_ready;
      load0    = in_fire && !S;
      load1    = in_fire && S;
      deliver0 = y0_valid_q && Y0_ready && !rst;
      deliver1 = y1_valid_q && Y1_ready && !rst;
   end

   always_comb begin
      y0_d       = y0_q;
      y1_d       = y1_q;
      y0_valid_d = y0_valid_q;
      y1_valid_d = y1_valid_q;
      if (load0) begin
         y0_d       = X;
         y0_valid_d = 1'b1;
      end else if (deliver0) begin
         y0_valid_d = 1'b0;
      end
      if (load1) begin
         y1_d       = X;
         y1_valid_d = 1'b1;
      end else if (deliver1) begin
         y1_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y0_q       <= '0;
         y1_q       <= '0;
         y0_valid_q <= 1'b0;
         y1_valid_q <= 1'b0;
      end else begin
         y0_q       <= y0_d;
         y1_q       <= y1_d;
         y0_valid_q <= y0_valid_d;
         y1_valid_q <= y1_valid_d;
      end
   end

   assign Y0       = y0_q;
   assign Y1       = y1_q;
   assign Y0_valid = y0_valid_q;
   assign Y1_valid = y1_valid_q;

`ifdef DEMUX_CNT_EN
   logic [15:0] cnt0_q, cnt0_d;
   logic [15:0] cnt1_q, cnt1_d;

   // Counters wrap naturally at 16 bits.
   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (deliver0) cnt0_d = cnt0_q + 16'd1;
      if (deliver1) cnt1_d = cnt1_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt0_q <= 16'h0000;
         cnt1_q <= 16'h0000;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign CNT0 = cnt0_q;
   assign CNT1 = cnt1_q;
`else
   assign CNT0 = 16'h0000;
   assign CNT1 = 16'h0000;
`endif

endmodule

// File: tb/tb_demux32_1_2_reg.sv
// Directed self-checking bench for demux32_1_2_reg (counter checks follow DEMUX_CNT_EN).
module tb_demux32_1_2_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] X;
   logic        S;
   logic        X_valid;
   logic        X_ready;
   logic [31:0] Y0, Y1;
   logic        Y0_valid, Y1_valid;
   logic        Y0_ready, Y1_ready;
   logic [15:0] CNT0, CNT1;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef DEMUX_CNT_EN
   localparam bit CntEn = 1'b1;
`else
   localparam bit CntEn = 1'b0;
`endif

   demux32_1_2_reg #(.W(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .X        (X),
      .S        (S),
      .X_valid  (X_valid),
      .X_ready  (X_ready),
      .Y0       (Y0),
      .Y1       (Y1),
      .Y0_valid (Y0_valid),
      .Y1_valid (Y1_valid),
      .Y0_ready (Y0_ready),
      .Y1_ready (Y1_ready),
      .CNT0     (CNT0),
      .CNT1     (CNT1)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; X = '0; S = 1'b0; X_valid = 1'b0; Y0_ready = 1'b0; Y1_ready = 1'b0;
      step();
      // Offer a word during reset: it must not be accepted.
      X = 32'hDEAD_BEEF; X_valid = 1'b1;
      #1 chk("xready_in_reset", X_ready, 0);
      step();
      chk("rst_y0_valid", Y0_valid, 0);
      chk("rst_y1_valid", Y1_valid, 0);
      chk("rst_y0", Y0, 0);
      chk("rst_y1", Y1, 0);
      chk("rst_cnt0", CNT0, 0);
      chk("rst_cnt1", CNT1, 0);

      // Routing to Y0
      rst = 1'b0; X = 32'hA5A5_0001; S = 1'b0; X_valid = 1'b1; Y0_ready = 1'b1;
      #1 chk("route_xready", X_ready, 1);
      step();
      X_valid = 1'b0;
      chk("route_y0", Y0, 32'hA5A5_0001);
      chk("route_y0_valid", Y0_valid, 1);
      chk("route_y1_valid", Y1_valid, 0);
      step();
      chk("route_drain_valid", Y0_valid, 0);
      chk("route_drain_data", Y0, 32'hA5A5_0001);

      // Backpressure on Y1
      X = 32'h1111; S = 1'b1; X_valid = 1'b1; Y1_ready = 1'b0;
      #1 chk("bp_first_ready", X_ready, 1);
      step();
      chk("bp_y1_first", Y1, 32'h1111);
      X = 32'h2222;
      #1 chk("bp_second_blocked", X_ready, 0);
      step();
      chk("bp_y1_hold", Y1, 32'h1111);
      chk("bp_y1_valid_hold", Y1_valid, 1);

      // Independence: Y0 still accepts while Y1 is stalled
      X = 32'h3333; S = 1'b0; Y0_ready = 1'b0;
      #1 chk("indep_xready", X_ready, 1);
      step();
      chk("indep_y0", Y0, 32'h3333);
      chk("indep_y0_valid", Y0_valid, 1);
      chk("indep_y1_hold", Y1, 32'h1111);

      // Release Y1: deliver and reload in one cycle while Y0 drains too
      X = 32'h2222; S = 1'b1; Y1_ready = 1'b1; Y0_ready = 1'b1;
      #1 chk("bp_release_ready", X_ready, 1);
      step();
      X_valid = 1'b0;
      chk("bp_y1_second", Y1, 32'h2222);
      chk("bp_y1_valid_kept", Y1_valid, 1);
      chk("both_y0_drained", Y0_valid, 0);
      chk("cnt0_two", CNT0, CntEn ? 32'd2 : 32'd0);
      chk("cnt1_one", CNT1, CntEn ? 32'd1 : 32'd0);
      step();
      chk("bp_y1_drained", Y1_valid, 0);
      chk("cnt1_two", CNT1, CntEn ? 32'd2 : 32'd0);

      // Reset then 8-word burst to Y0
      rst = 1'b1;
      step();
      rst = 1'b0; S = 1'b0; Y0_ready = 1'b1; X_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         X = 32'hC0DE_0000 + i;
         #1 chk("burst_xready", X_ready, 1);
         step();
         chk("burst_data", Y0, 32'hC0DE_0000 + i);
         chk("burst_valid", Y0_valid, 1);
      end
      X_valid = 1'b0;
      step();
      chk("burst_end_valid", Y0_valid, 0);
      chk("burst_cnt0", CNT0, CntEn ? 32'd8 : 32'd0);
      chk("burst_cnt1", CNT1, 0);

`ifdef DEMUX_CNT_EN
      // 65537 deliveries on Y1 wrap CNT1 to 1
      S = 1'b1; Y1_ready = 1'b1; X_valid = 1'b1;
      for (int i = 0; i < 65537; i++) begin
         X = i;
         step();
      end
      X_valid = 1'b0;
      step();
      chk("wrap_cnt1", CNT1, 1);
      chk("wrap_last_data", Y1, 32'd65536);
`endif

      // Stall hold on Y0, then reset with a word pending
      X = 32'h4444; S = 1'b0; X_valid = 1'b1; Y0_ready = 1'b0;
      step();
      X_valid = 1'b0;
      step();
      step();
      chk("stall_y0", Y0, 32'h4444);
      chk("stall_valid", Y0_valid, 1);
      rst = 1'b1; Y0_ready = 1'b1; X = 32'h5555; X_valid = 1'b1;
      #1 chk("rst_mid_xready", X_ready, 0);
      step();
      chk("rst_mid_y0", Y0, 0);
      chk("rst_mid_y0_valid", Y0_valid, 0);
      chk("rst_mid_y1", Y1, 0);
      chk("rst_mid_y1_valid", Y1_valid, 0);
      chk("rst_mid_cnt0", CNT0, 0);
      chk("rst_mid_cnt1", CNT1, 0);
      rst = 1'b0; X_valid = 1'b0;
      step();
      chk("post_rst_valid", Y0_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
